// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: debounces the scanner's one-hot key vector, builds a BCD entry
// and hands committed entries out over valid/ready. Optional idle timeout: KEYPAD_TIMEOUT_EN.
module keypad_entry_ctrl #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned DEBOUNCE_CYC = 16,
    parameter int unsigned TIMEOUT_CYC  = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [11:0]           key_data,
    output logic                  key_event,
    output logic [3:0]            key_code,
    output logic                  key_dropped,
    output logic [4*DIGITS-1:0]   entry_bcd,
    output logic [2:0]            digit_cnt,
    output logic                  overflow,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [2:0]            out_cnt,
    output logic                  timeout
);

    localparam int unsigned KEY_W = 12;
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYC + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [KEY_W-1:0]   ks_q, cand_q, cand_d;
    logic [DB_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic               accept;
    logic               ks_valid;
    logic [3:0]         cand_code;

    logic               event_q;
    logic [3:0]         code_q, code_d;
    logic               drop_q, drop_d;
    logic [BCD_W-1:0]   entry_q, entry_d;
    logic [2:0]         dcnt_q, dcnt_d;
    logic               ovf_q, ovf_d;
    logic               ov_q, ov_d;
    logic [BCD_W-1:0]   obcd_q, obcd_d;
    logic [2:0]         ocnt_q, ocnt_d;
    logic               tmo_q;
    logic               tmo_fire;

    function automatic logic [3:0] key_to_code(input logic [KEY_W-1:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int unsigned i = 0; i < 9; i++) begin
            if (v[i]) c = 4'(i + 1);
        end
        if (v[9])  c = 4'd10;
        if (v[10]) c = 4'd0;
        if (v[11]) c = 4'd11;
        return c;
    endfunction

    assign ks_valid  = $onehot(ks_q);
    assign cnt_inc   = cnt_q + DB_W'(1);
    assign cand_code = key_to_code(cand_q);

    // Debounce FSM: a press is accepted once, re-armed only after a stable release
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ks_valid) begin
                    cand_d  = ks_q;
                    cnt_d   = DB_W'(1);
                    state_d = PRESS_DB;
                end
            end
            PRESS_DB: begin
                if (ks_q == cand_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DB_W'(DEBOUNCE_CYC)) begin
                        state_d = HELD;
                        accept  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            HELD: begin
                if (ks_q != cand_q) begin
                    state_d = RELEASE_DB;
                    cnt_d   = (ks_q == '0) ? DB_W'(1) : '0;
                end
            end
            RELEASE_DB: begin
                if (ks_q == '0) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DB_W'(DEBOUNCE_CYC)) state_d = IDLE;
                end else begin
                    cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

`ifdef KEYPAD_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] idle_q, idle_d, idle_inc;

    assign idle_inc = idle_q + TO_W'(1);

    // Idle counter runs only while an uncommitted entry sits with no pending handoff
    always_comb begin
        idle_d   = idle_q;
        tmo_fire = 1'b0;
        if (accept || dcnt_q == 3'd0) begin
            idle_d = '0;
        end else if (!ov_q) begin
            if (idle_inc == TO_W'(TIMEOUT_CYC)) begin
                idle_d   = '0;
                tmo_fire = 1'b1;
            end else begin
                idle_d = idle_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) idle_q <= '0;
        else      idle_q <= idle_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYC);
    assign tmo_fire = 1'b0;
`endif

    // Key action uses pre-edge state; a pending handoff swallows the key
    always_comb begin
        code_d  = code_q;
        drop_d  = 1'b0;
        entry_d = entry_q;
        dcnt_d  = dcnt_q;
        ovf_d   = ovf_q;
        ov_d    = ov_q;
        obcd_d  = obcd_q;
        ocnt_d  = ocnt_q;
        if (ov_q && out_ready) ov_d = 1'b0;
        if (tmo_fire) begin
            entry_d = '0;
            dcnt_d  = 3'd0;
            ovf_d   = 1'b0;
        end
        if (accept) begin
            code_d = cand_code;
            if (ov_q) begin
                drop_d = 1'b1;
            end else if (cand_code <= 4'd9) begin
                if (dcnt_q < 3'(DIGITS)) begin
                    entry_d = (entry_q << 4) | BCD_W'(cand_code);
                    dcnt_d  = dcnt_q + 3'd1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (cand_code == 4'd10) begin
                entry_d = '0;
                dcnt_d  = 3'd0;
                ovf_d   = 1'b0;
            end else if (dcnt_q != 3'd0) begin
                obcd_d  = entry_q;
                ocnt_d  = dcnt_q;
                ov_d    = 1'b1;
                entry_d = '0;
                dcnt_d  = 3'd0;
                ovf_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ks_q    <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            event_q <= 1'b0;
            code_q  <= 4'd0;
            drop_q  <= 1'b0;
            entry_q <= '0;
            dcnt_q  <= 3'd0;
            ovf_q   <= 1'b0;
            ov_q    <= 1'b0;
            obcd_q  <= '0;
            ocnt_q  <= 3'd0;
            tmo_q   <= 1'b0;
        end else begin
            ks_q    <= key_data;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            event_q <= accept;
            code_q  <= code_d;
            drop_q  <= drop_d;
            entry_q <= entry_d;
            dcnt_q  <= dcnt_d;
            ovf_q   <= ovf_d;
            ov_q    <= ov_d;
            obcd_q  <= obcd_d;
            ocnt_q  <= ocnt_d;
            tmo_q   <= tmo_fire;
        end
    end

    assign key_event   = event_q;
    assign key_code    = code_q;
    assign key_dropped = drop_q;
    assign entry_bcd   = entry_q;
    assign digit_cnt   = dcnt_q;
    assign overflow    = ovf_q;
    assign out_valid   = ov_q;
    assign out_bcd     = obcd_q;
    assign out_cnt     = ocnt_q;
    assign timeout     = tmo_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed keypad scenarios plus random key traffic checked
// every cycle against a run-length behavioural model.
module tb_keypad_entry_ctrl;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned DB     = 4;
    localparam int unsigned TO     = 50;
    localparam int unsigned BW     = 4 * DIGITS;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [11:0]       key_data = '0;
    logic              out_ready = 1'b0;
    logic              key_event, key_dropped, overflow, out_valid, timeout;
    logic [3:0]        key_code;
    logic [BW-1:0]     entry_bcd, out_bcd;
    logic [2:0]        digit_cnt, out_cnt;

    keypad_entry_ctrl #(.DIGITS(DIGITS), .DEBOUNCE_CYC(DB), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .key_data(key_data),
        .key_event(key_event), .key_code(key_code), .key_dropped(key_dropped),
        .entry_bcd(entry_bcd), .digit_cnt(digit_cnt), .overflow(overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd),
        .out_cnt(out_cnt), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_ev = 0, n_drop = 0, n_tmo = 0, ev_cyc = 0, tmo_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int key_code_of(input logic [11:0] v);
        for (int i = 0; i < 12; i++) begin
            if (v[i]) return (i < 9) ? i + 1 : (i == 9) ? 10 : (i == 10) ? 0 : 11;
        end
        return 0;
    endfunction

    // Behavioural model: armed/run-length view of the debounce plus the entry rules
    logic [11:0]   m_ks, m_cand;
    bit            m_armed;
    int            m_run, m_zrun, m_cnt, m_ocnt, m_idle;
    bit            m_ev, m_drop, m_ovf, m_valid, m_tmo;
    logic [3:0]    m_code;
    logic [BW-1:0] m_entry, m_obcd;

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ks = '0; m_cand = '0; m_armed = 1; m_run = 0; m_zrun = 0;
            m_cnt = 0; m_ocnt = 0; m_idle = 0; m_ev = 0; m_drop = 0; m_ovf = 0;
            m_valid = 0; m_tmo = 0; m_code = '0; m_entry = '0; m_obcd = '0;
        end else begin
            logic [11:0] s;
            bit pv;
            int pc, c;
            s = m_ks;
            m_ks = key_data;
            pv = m_valid;
            pc = m_cnt;
            m_ev = 0; m_drop = 0; m_tmo = 0;
            if (!m_armed) begin
                m_zrun = (s == 0) ? m_zrun + 1 : 0;
                if (m_zrun >= DB) m_armed = 1;
            end else if (m_run == 0) begin
                if ($countones(s) == 1) begin
                    m_cand = s;
                    m_run = 1;
                end
            end else if (s == m_cand) begin
                m_run++;
                if (m_run == DB) begin
                    m_ev = 1; m_armed = 0; m_zrun = 0; m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            if (m_ev) begin
                c = key_code_of(m_cand);
                m_code = 4'(c);
                if (pv) m_drop = 1;
                else if (c <= 9) begin
                    if (m_cnt < DIGITS) begin
                        m_entry = BW'((m_entry << 4) | c);
                        m_cnt++;
                    end else m_ovf = 1;
                end else if (c == 10) begin
                    m_entry = '0; m_cnt = 0; m_ovf = 0;
                end else if (m_cnt > 0) begin
                    m_obcd = m_entry; m_ocnt = m_cnt; m_valid = 1;
                    m_entry = '0; m_cnt = 0; m_ovf = 0;
                end
            end
            if (pv && out_ready) m_valid = 0;
`ifdef KEYPAD_TIMEOUT_EN
            if (m_ev || pc == 0) m_idle = 0;
            else if (!pv) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_idle = 0; m_tmo = 1; m_entry = '0; m_cnt = 0; m_ovf = 0;
                end
            end
`endif
        end
    end

    // Per-cycle comparison against the model, plus event counters for directed checks
    always @(negedge clk) begin
        if (rst) begin
            check("key_event", 32'(key_event), 32'(m_ev));
            check("key_code", 32'(key_code), 32'(m_code));
            check("key_dropped", 32'(key_dropped), 32'(m_drop));
            check("entry_bcd", 32'(entry_bcd), 32'(m_entry));
            check("digit_cnt", 32'(digit_cnt), 32'(m_cnt));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("out_bcd", 32'(out_bcd), 32'(m_obcd));
            check("out_cnt", 32'(out_cnt), 32'(m_ocnt));
            check("timeout", 32'(timeout), 32'(m_tmo));
            if (key_event) begin n_ev++; ev_cyc = cyc; end
            if (key_dropped) n_drop++;
            if (timeout) begin n_tmo++; tmo_cyc = cyc; end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [11:0] k);
        key_data = k;
        tick(8);
        key_data = '0;
        tick(8);
    endtask

    initial begin
        int lat, e0, d0, t0, ec;
        logic [11:0] v;
        tick(3);
        check("rst_entry", 32'(entry_bcd), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_event", 32'(key_event), 32'h0);
        rst = 1'b1;
        tick(2);
        check("idle_cnt", 32'(digit_cnt), 32'h0);

        // single clean press of '2'
        e0 = n_ev;
        key_data = 12'h002;
        lat = 0;
        for (int k = 1; k <= 30 && lat == 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (key_event) lat = k;
        end
        check("press_latency", 32'(lat), 32'd5);
        tick(15);
        key_data = '0;
        tick(8);
        check("one_event", 32'(n_ev - e0), 32'd1);
        check("code_2", 32'(key_code), 32'd2);
        check("entry_2", 32'(entry_bcd), 32'h0002);
        check("cnt_1", 32'(digit_cnt), 32'd1);

        // bouncing '5' then stable
        e0 = n_ev;
        repeat (3) begin
            key_data = 12'h010; tick(2);
            key_data = '0;      tick(2);
        end
        check("bounce_no_event", 32'(n_ev - e0), 32'd0);
        key_data = 12'h010; tick(12);
        key_data = '0;      tick(8);
        check("bounce_one_event", 32'(n_ev - e0), 32'd1);
        check("code_5", 32'(key_code), 32'd5);
        check("entry_25", 32'(entry_bcd), 32'h0025);

        // clear, fill past capacity, commit
        press(12'h200);
        check("star_cnt", 32'(digit_cnt), 32'd0);
        for (int i = 0; i < 5; i++) press(12'(1 << i));
        check("entry_1234", 32'(entry_bcd), 32'h1234);
        check("ovf_set", 32'(overflow), 32'd1);
        press(12'h800);
        check("commit_valid", 32'(out_valid), 32'd1);
        check("commit_bcd", 32'(out_bcd), 32'h1234);
        check("commit_cnt", 32'(out_cnt), 32'd4);
        check("commit_clr", 32'(entry_bcd), 32'h0);
        check("commit_ovf", 32'(overflow), 32'd0);

        // key while handoff pending is dropped; then one-cycle ready
        d0 = n_drop;
        press(12'h040);
        check("drop_pulse", 32'(n_drop - d0), 32'd1);
        check("drop_entry", 32'(digit_cnt), 32'd0);
        check("drop_hold", 32'(out_bcd), 32'h1234);
        out_ready = 1'b1; tick(1); out_ready = 1'b0;
        check("hs_fall", 32'(out_valid), 32'd0);

        // empty commit, star clear, multi-bit input
        press(12'h800);
        check("empty_hash", 32'(out_valid), 32'd0);
        press(12'h100);
        press(12'h200);
        check("nine_star", 32'(digit_cnt), 32'd0);
        e0 = n_ev;
        key_data = 12'h003; tick(20);
        key_data = '0;      tick(8);
        check("multibit", 32'(n_ev - e0), 32'd0);

        // idle behaviour after a single digit
        t0 = n_tmo;
        press(12'h080);
        ec = ev_cyc;
`ifdef KEYPAD_TIMEOUT_EN
        for (int k = 0; k < 200 && n_tmo == t0; k++) tick(1);
        check("tmo_seen", 32'(n_tmo - t0), 32'd1);
        check("tmo_delay", 32'(tmo_cyc - ec), 32'd50);
        check("tmo_cnt", 32'(digit_cnt), 32'd0);
        tick(60);
        check("tmo_once", 32'(n_tmo - t0), 32'd1);
`else
        tick(80);
        check("no_tmo", 32'(n_tmo - t0), 32'd0);
        check("persist", 32'(entry_bcd), 32'h0008);
        press(12'h200);
`endif

        // random key traffic with one mid-run reset
        for (int seg = 0; seg < 400; seg++) begin
            int r, len;
            if (seg == 200) begin
                rst = 1'b0; tick(2); rst = 1'b1;
            end
            r = $urandom_range(0, 99);
            if (r < 45)      v = '0;
            else if (r < 90) v = 12'(1) << $urandom_range(0, 11);
            else             v = 12'($urandom);
            key_data = v;
            len = $urandom_range(1, 12);
            for (int k = 0; k < len; k++) begin
                out_ready = ($urandom_range(0, 3) == 0);
                tick(1);
            end
        end
        key_data = '0;
        out_ready = 1'b0;
        tick(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
